alu_arbiter_64: RTL and testbench
=================================

ALU_ARBITER_64 -- requirements
Module: alu_arbiter_64

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester n's operation accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101-111 illegal.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_data  output  WIDTH  result.
REQ-011 SHALL have port res_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have ports res_zero, res_carry, res_ovf, res_err  output  1 each  status flags.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; at most one operation in flight.
REQ-014 In IDLE, ready SHALL be driven combinationally high for exactly one requester with valid=1, chosen by a round-robin pointer; both readys SHALL be 0 in EXEC and DONE.
REQ-015 Round-robin: with both valid, grant the requester the pointer names; the pointer SHALL then point to the other requester; with one valid, grant it regardless of pointer and point to the other.
REQ-016 Accept (valid & ready) SHALL capture op, a, b and requester id into internal registers and move IDLE->EXEC.
REQ-017 EXEC SHALL compute the result from the captured operands into the output registers and move to DONE with res_valid=1 on the next cycle; accept at cycle N gives res_valid at N+2.
REQ-018 DONE SHALL hold res_valid, res_data, res_id and all flags stable until res_ready=1; on that handshake, go to IDLE with res_valid=0 on the next cycle.
REQ-019 An accept SHALL NOT occur in the same cycle as a result handshake; minimum spacing between accepts is 3 cycles.
REQ-020 AND/OR/XOR: bitwise; carry=0, ovf=0.
REQ-021 ADD: res_data = (a+b) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum; ovf = signed two's-complement overflow.
REQ-022 SUB: res_data = (a-b) mod 2^WIDTH; carry = 1 when no borrow (a >= b unsigned); ovf = signed overflow.
REQ-023 res_zero SHALL be 1 exactly when res_data == 0, for all legal ops.
REQ-024 Illegal opcode: res_data=0, res_err=1, res_zero=0, carry=0, ovf=0; for legal opcodes res_err=0.
REQ-025 Requester inputs SHALL be ignored outside the accept cycle; operand changes after accept do not affect the result.

Reset
REQ-026 While rst=1 at a clock edge: state IDLE, pointer to requester 0, res_valid=0, res_data=0, res_id=0, all flags 0.
REQ-027 Reset asserted in EXEC or DONE SHALL discard the in-flight operation with no res_valid pulse; readys are 0 during the reset cycle.
REQ-028 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-029 AND: req0 op=000, a=64'hFF00, b=64'h0FF0 -> res_data=64'h0F00, res_id=0, zero=0, err=0, res_valid 2 cycles after accept.
REQ-030 ADD wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> res_data=0, zero=1, carry=1, ovf=0.
REQ-031 SUB overflow: a=64'h8000_0000_0000_0000, b=1 -> res_data=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, carry=1.
REQ-032 Arbitration: after reset both valid continuously -> grants alternate 0,1,0,1 (res_id sequence matches); req1 alone -> granted immediately.
REQ-033 Backpressure/illegal: op=111 with res_ready low 5 cycles -> res_valid, res_data=0, res_err=1 stable all 5 cycles, no new ready; res_ready high -> IDLE next cycle.
REQ-034 Reset in DONE -> next cycle res_valid=0, all outputs 0, pointer at requester 0, next accept goes to req0 when both valid.

Source files
------------

// File: rtl/alu_arbiter_64.sv
// alu_arbiter_64: two-requester round-robin front end feeding a
// single-issue ALU with a registered result and status flags.
module alu_arbiter_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             res_err
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic             ptr;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             grant0;
  logic             grant1;
  logic             idle;

  // ptr names the requester that wins a tie
  assign grant0 = req0_valid & (~req1_valid | ~ptr);
  assign grant1 = req1_valid & (~req0_valid | ptr);
  assign idle   = (state == IDLE) & ~rst;

  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_data;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;

  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    unique case (1'b1)
      op_q == 3'b000: alu_data = a_q & b_q;
      op_q == 3'b001: alu_data = a_q | b_q;
      op_q == 3'b010: alu_data = a_q ^ b_q;
      op_q == 3'b011: begin
        alu_data  = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a_q[MSB] == b_q[MSB])
                  & (sum[MSB] != a_q[MSB]);
      end
      op_q == 3'b100: begin
        alu_data  = dif[MSB:0];
        alu_carry = ~dif[WIDTH];
        alu_ovf   = (a_q[MSB] != b_q[MSB])
                  & (dif[MSB] != a_q[MSB]);
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            id_q  <= req1_ready;
            op_q  <= req1_ready ? req1_op : req0_op;
            a_q   <= req1_ready ? req1_a : req0_a;
            b_q   <= req1_ready ? req1_b : req0_b;
            ptr   <= ~req1_ready;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_data;
          res_zero  <= ~alu_err & (alu_data == '0);
          res_carry <= alu_carry;
          res_ovf   <= alu_ovf;
          res_err   <= alu_err;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_64.sv
// Scoreboard bench for alu_arbiter_64: random and directed traffic
// checked against a behavioural arbitration/ALU model.
module tb_alu_arbiter_64;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic [2:0]   req0_op = '0;
  logic [2:0]   req1_op = '0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_zero;
  logic         res_carry;
  logic         res_ovf;
  logic         res_err;

  always #5 clk = ~clk;

  alu_arbiter_64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_zero  (res_zero),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_err   (res_err)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   m_busy = 0;
  bit   m_ptr = 0;
  int   acc_cyc = 0;
  bit   prev_valid = 0;
  res_t prev_res;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: signed results checked for fitting in W bits,
  // unsigned carry/borrow from magnitude comparisons.
  function automatic res_t model(input logic id,
                                 input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t         r;
    logic [W+1:0] sa;
    logic [W+1:0] sb;
    logic [W+1:0] ss;
    r = '0;
    r.id = id;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    ss = '0;
    case (op)
      3'd0: r.data = a & b;
      3'd1: r.data = a | b;
      3'd2: r.data = a ^ b;
      3'd3: begin
        r.data  = a + b;
        r.carry = (a > ~b);
        ss      = sa + sb;
      end
      3'd4: begin
        r.data  = a - b;
        r.carry = (a >= b);
        ss      = sa - sb;
      end
      default: r.err = 1'b1;
    endcase
    if (op == 3'd3 || op == 3'd4)
      r.ovf = (ss[W+1:W-1] != 3'b000) && (ss[W+1:W-1] != 3'b111);
    r.zero = !r.err && (r.data == '0);
    return r;
  endfunction

  always @(negedge clk) begin : mon
    res_t cur;
    res_t e;
    bit   was_busy;
    bit   g;
    cyc++;
    cur = {res_id, res_data, res_zero, res_carry, res_ovf, res_err};
    if (rst) begin
      chk("ready_in_reset", {req0_ready, req1_ready}, 0);
      exp_q.delete();
      m_busy = 0;
      m_ptr = 0;
      prev_valid = 0;
    end else begin
      was_busy = m_busy;
      if (!was_busy) chk("idle_valid", res_valid, 0);
      if (!was_busy && (req0_valid || req1_valid)) begin
        g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        chk("grant", {req0_ready, req1_ready}, g ? 2'b01 : 2'b10);
        exp_q.push_back(g ? model(1'b1, req1_op, req1_a, req1_b)
                          : model(1'b0, req0_op, req0_a, req0_b));
        m_ptr = !g;
        m_busy = 1;
        acc_cyc = cyc;
      end else begin
        chk("no_grant", {req0_ready, req1_ready}, 0);
      end
      if (was_busy && cyc == acc_cyc + 1) chk("early_valid", res_valid, 0);
      if (was_busy && cyc == acc_cyc + 2) chk("latency", res_valid, 1);
      if (res_valid && was_busy) begin
        if (prev_valid) chk("hold", cur, prev_res);
        prev_res = cur;
        prev_valid = 1;
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", res_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("id", res_id, e.id);
            chk("data", res_data, e.data);
            chk("zero", res_zero, e.zero);
            chk("carry", res_carry, e.carry);
            chk("ovf", res_ovf, e.ovf);
            chk("err", res_err, e.err);
          end
          m_busy = 0;
          prev_valid = 0;
        end
      end else if (prev_valid) begin
        chk("valid_dropped", res_valid, 1);
        prev_valid = 0;
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue(input bit r, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit got;
    @(posedge clk); #1;
    if (r) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
    got = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin
        got = 1;
        break;
      end
      n++;
    end
    chk("accept_wait", n, 0);
    chk("accepted", got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = pick(); req0_b = pick(); req0_op = 3'($urandom);
    req1_a = pick(); req1_b = pick(); req1_op = 3'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 10);
    chk("result_wait", res_valid, 1);
  endtask

  task automatic expect_res(input logic id, input logic [W-1:0] d,
                            input logic z, input logic c,
                            input logic o, input logic er);
    wait_valid();
    chk("dir_id", res_id, id);
    chk("dir_data", res_data, d);
    chk("dir_flags", {res_zero, res_carry, res_ovf, res_err},
        {z, c, o, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_outs",
        {res_valid, res_data, res_id, res_zero, res_carry, res_ovf, res_err},
        0);

    res_ready = 1;
    issue(0, 3'b000, 64'hFF00, 64'h0FF0);
    expect_res(0, 64'h0F00, 0, 0, 0, 0);
    issue(0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    expect_res(0, 64'd0, 1, 1, 0, 0);
    issue(1, 3'b100, 64'h8000_0000_0000_0000, 64'd1);
    expect_res(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0);

    do_reset();
    req0_valid = 1; req0_op = 3'b010; req0_a = pick(); req0_b = pick();
    req1_valid = 1; req1_op = 3'b011; req1_a = pick(); req1_b = pick();
    for (int k = 0; k < 4; k++) begin
      wait_valid();
      chk("alt_id", res_id, k[0]);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);

    res_ready = 0;
    issue(0, 3'b111, pick(), pick());
    wait_valid();
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 0);
      chk("bp_err", {res_err, res_zero}, 2'b10);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    res_ready = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", res_valid, 0);

    res_ready = 0;
    issue(1, 3'b011, pick(), pick());
    wait_valid();
    do_reset();
    @(negedge clk);
    chk("rst_done_outs",
        {res_valid, res_data, res_id, res_zero, res_carry, res_ovf, res_err},
        0);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = pick(); req0_b = pick();
      req1_a = pick(); req1_b = pick();
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    repeat (8) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
